hazard_stall_unit: RTL

Parametrised ID-stage data-hazard detector for the pipelined MIPS core. It generalises the fixed two-read-port, rs/rt-only stall logic to N read ports, configurable per-stage stall lengths and a forwarding-aware mode that stalls only on load-use. It adds HI/LO hazards, a multi-cycle mul/div busy interlock, $0 exemption, flush handling and a stall-cause report. It sits beside the IF/ID and ID/EXE pipeline registers and drives their hold enables.

---
 rtl/hazard_stall_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : ID-stage data-hazard detector. Checks N register read ports
//                and HI/LO reads against EXE/MEM producers, applies per-stage
//                stall lengths or load-use-only stalls when forwarding exists,
//                interlocks on a busy mul/div unit, and reports the cause.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int EXE_STALL = 2,
    parameter int MEM_STALL = 1,
    parameter int FWD_MODE  = 0,
    parameter int CNT_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NUM_RD*ADDR_W-1:0] id_raddr,
    input  logic [NUM_RD-1:0]        id_rena,
    input  logic                     id_rd_hi,
    input  logic                     id_rd_lo,
    input  logic                     id_uses_md,
    input  logic [ADDR_W-1:0]        exe_waddr,
    input  logic                     exe_wena,
    input  logic                     exe_is_load,
    input  logic                     exe_hi_wena,
    input  logic                     exe_lo_wena,
    input  logic [ADDR_W-1:0]        mem_waddr,
    input  logic                     mem_wena,
    input  logic                     mem_hi_wena,
    input  logic                     mem_lo_wena,
    input  logic                     md_busy,
    input  logic                     flush,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [2:0]               stall_cause
);

    localparam int         MAX_STALL    = (EXE_STALL > MEM_STALL) ? EXE_STALL : MEM_STALL;
    localparam logic [2:0] C_CAUSE_NONE = 3'd0;
    localparam logic [2:0] C_CAUSE_EXE  = 3'd1;
    localparam logic [2:0] C_CAUSE_MEM  = 3'd2;
    localparam logic [2:0] C_CAUSE_HILO = 3'd3;
    localparam logic [2:0] C_CAUSE_LOAD = 3'd4;
    localparam logic [2:0] C_CAUSE_MD   = 3'd5;

    logic [NUM_RD-1:0] w_exe_match;
    logic [NUM_RD-1:0] w_mem_match;

    // Per-port compare; register $0 is hard-wired zero and never hazards.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
        logic [ADDR_W-1:0] w_raddr;
        logic              w_live;
        assign w_raddr = id_raddr[gi*ADDR_W +: ADDR_W];
        assign w_live  = id_valid & id_rena[gi] & (w_raddr != '0);
        assign w_exe_match[gi] = w_live & exe_wena & (w_raddr == exe_waddr);
        assign w_mem_match[gi] = w_live & mem_wena & (w_raddr == mem_waddr);
    end

    logic w_exe_rf, w_mem_rf, w_hilo_exe, w_hilo_mem, w_load_use, w_interlock;

    assign w_exe_rf    = |w_exe_match;
    assign w_mem_rf    = |w_mem_match;
    assign w_hilo_exe  = id_valid & ((id_rd_hi & exe_hi_wena) | (id_rd_lo & exe_lo_wena));
    assign w_hilo_mem  = id_valid & ((id_rd_hi & mem_hi_wena) | (id_rd_lo & mem_lo_wena));
    assign w_load_use  = w_exe_rf & exe_is_load;
    assign w_interlock = md_busy & id_uses_md & id_valid;

    logic [3:0] w_n_req;
    logic [2:0] w_idle_cause;

    // Total stall length and cause for a fresh evaluation (counter idle).
    always_comb begin
        w_n_req      = 4'd0;
        w_idle_cause = C_CAUSE_NONE;
        if (FWD_MODE != 0) begin
            if (w_load_use) w_n_req = 4'd1;
        end else if ((w_exe_rf | w_hilo_exe) && (w_mem_rf | w_hilo_mem)) begin
            w_n_req = 4'(MAX_STALL);
        end else if (w_exe_rf | w_hilo_exe) begin
            w_n_req = 4'(EXE_STALL);
        end else if (w_mem_rf | w_hilo_mem) begin
            w_n_req = 4'(MEM_STALL);
        end

        if (w_interlock) begin
            w_idle_cause = C_CAUSE_MD;
        end else if (FWD_MODE != 0) begin
            if (w_load_use) w_idle_cause = C_CAUSE_LOAD;
        end else if (w_hilo_exe | w_hilo_mem) begin
            w_idle_cause = C_CAUSE_HILO;
        end else if (w_exe_rf) begin
            w_idle_cause = C_CAUSE_EXE;
        end else if (w_mem_rf) begin
            w_idle_cause = C_CAUSE_MEM;
        end
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cause_q, cause_d;
    logic             w_stall;
    logic [2:0]       w_cause;

    // Flush aborts everything; a loaded counter holds the stall without re-evaluating.
    always_comb begin
        cnt_d   = '0;
        cause_d = C_CAUSE_NONE;
        w_stall = 1'b0;
        w_cause = C_CAUSE_NONE;
        if (flush) begin
            w_stall = 1'b0;
        end else if (cnt_q != '0) begin
            w_stall = 1'b1;
            w_cause = cause_q;
            cnt_d   = cnt_q - CNT_W'(1);
            cause_d = (cnt_q > CNT_W'(1)) ? cause_q : C_CAUSE_NONE;
        end else begin
            w_stall = (w_n_req != 4'd0) | w_interlock;
            w_cause = w_stall ? w_idle_cause : C_CAUSE_NONE;
            if (w_n_req > 4'd1) begin
                cnt_d   = CNT_W'(w_n_req - 4'd1);
                cause_d = w_idle_cause;
            end
        end
    end

    // Stall counter and latched cause; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            cause_q <= C_CAUSE_NONE;
        end else begin
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign stall       = rst & w_stall;
    assign stall_cause = rst ? w_cause : C_CAUSE_NONE;
    assign stall_cnt   = rst ? cnt_q : '0;

endmodule
`default_nettype wire
